// File: rtl/pipe_tx_arbiter.sv
`default_nettype none
// ============================================================================
// pipe_tx_arbiter : round-robin packet arbiter for the pipe transmit port;
//                   each packet is prefixed by a {tag, source, seq} header.
// Revision        : 1.0
// ============================================================================
module pipe_tx_arbiter #(
  parameter int         NUM_SRC = 4,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  en,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC-1:0]    src_last,
  input  logic [16*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic                  sys_tx_valid,
  input  logic                  sys_tx_ready,
  output logic [15:0]           sys_tx,
  output logic                  busy,
  output logic [3:0]            grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_INIT = 4'(NUM_SRC - 1);
  localparam logic [4:0] C_NUM_SRC   = 5'(NUM_SRC);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_grant;
  logic [3:0]   r_last_grant;
  logic [7:0]   r_seq;

  // Padding to 16 sources lets a 4-bit grant index every vector directly.
  logic [15:0]  w_valid_pad;
  logic [15:0]  w_last_pad;
  logic [255:0] w_data_pad;
  logic [15:0]  w_grant_data;
  logic         w_grant_valid;
  logic         w_grant_last;
  logic         w_data_end;
  logic         w_pick_ok;
  logic [3:0]   w_pick;
  logic [4:0]   w_sum;
  logic [3:0]   w_idx;

  assign w_valid_pad   = 16'(src_valid);
  assign w_last_pad    = 16'(src_last);
  assign w_data_pad    = 256'(src_data);
  assign w_grant_valid = w_valid_pad[r_grant];
  assign w_grant_last  = w_last_pad[r_grant];
  assign w_grant_data  = w_data_pad[{r_grant, 4'b0000} +: 16];
  assign w_data_end    = (r_state == S_DATA) && w_grant_valid && sys_tx_ready && w_grant_last;

  // First requester after last_grant, wrapping modulo NUM_SRC.
  always_comb begin
    w_pick_ok = 1'b0;
    w_pick    = 4'd0;
    w_sum     = 5'd0;
    w_idx     = 4'd0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      w_sum = {1'b0, r_last_grant} + 5'(i);
      w_idx = 4'((w_sum >= C_NUM_SRC) ? (w_sum - C_NUM_SRC) : w_sum);
      if (!w_pick_ok && w_valid_pad[w_idx]) begin
        w_pick_ok = 1'b1;
        w_pick    = w_idx;
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    sys_tx_valid = 1'b0;
    sys_tx       = 16'h0000;
    busy         = 1'b0;
    grant_id     = r_grant;
    case (r_state)
      S_IDLE: begin
        if (en && w_pick_ok) begin
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        sys_tx_valid = 1'b1;
        sys_tx       = {HDR_TAG, r_grant, r_seq};
        busy         = 1'b1;
        if (sys_tx_ready) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        sys_tx_valid = w_grant_valid;
        sys_tx       = w_grant_valid ? w_grant_data : 16'h0000;
        busy         = 1'b1;
        if (w_data_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Outputs are forced quiet for the whole reset cycle, so no beat of an
    // abandoned packet is accepted while s_rst is high.
    if (s_rst) begin
      sys_tx_valid = 1'b0;
      sys_tx       = 16'h0000;
      busy         = 1'b0;
      grant_id     = 4'd0;
    end
  end

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !s_rst && (r_state == S_DATA) && (r_grant == 4'(i)) && sys_tx_ready;
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_grant      <= 4'd0;
      r_last_grant <= C_LAST_INIT;
      r_seq        <= 8'd0;
    end else begin
      if ((r_state == S_IDLE) && en && w_pick_ok) begin
        r_grant <= w_pick;
      end
      if ((r_state == S_HDR) && sys_tx_ready) begin
        r_seq <= r_seq + 8'd1;
      end
      if (w_data_end) begin
        r_last_grant <= r_grant;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pipe_tx_arbiter : vector table, header-wrap sequence and randomized
//                      packet traffic against a transaction-level model.
// Revision           : 1.0
// ============================================================================
module tb_pipe_tx_arbiter;

  localparam int NSRC = 4;
  localparam int NVEC = 33;

  logic              s_clk = 1'b0;
  logic              s_rst;
  logic              en;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_last;
  logic [16*NSRC-1:0] src_data;
  logic [NSRC-1:0]   src_ready;
  logic              sys_tx_valid;
  logic              sys_tx_ready;
  logic [15:0]       sys_tx;
  logic              busy;
  logic [3:0]        grant_id;

  int total = 0;
  int bad   = 0;

  pipe_tx_arbiter #(.NUM_SRC(NSRC), .HDR_TAG(4'hA)) dut (
    .s_clk        (s_clk),
    .s_rst        (s_rst),
    .en           (en),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .sys_tx_valid (sys_tx_valid),
    .sys_tx_ready (sys_tx_ready),
    .sys_tx       (sys_tx),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 s_clk = ~s_clk;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [3:0]  v;
    logic [3:0]  l;
    logic        rdy;
    logic [15:0] d;
    logic        txv;
    logic [15:0] tx;
    logic [3:0]  srdy;
    logic        bsy;
    logic [3:0]  gid;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic rst, input logic e, input logic [3:0] v,
                              input logic [3:0] l, input logic rdy, input logic [15:0] d,
                              input logic txv, input logic [15:0] tx, input logic [3:0] srdy,
                              input logic bsy, input logic [3:0] gid);
    vec_t r;
    r.rst = rst; r.en = e; r.v = v; r.l = l; r.rdy = rdy; r.d = d;
    r.txv = txv; r.tx = tx; r.srdy = srdy; r.bsy = bsy; r.gid = gid;
    return r;
  endfunction

  function automatic logic [15:0] word(input int s, input int p, input int b);
    return {4'(s), 4'(p), 8'(b)};
  endfunction

  // Random-phase traffic description and model state.
  int          npk  [NSRC];
  int          plen [NSRC][8];
  int          dpk  [NSRC];
  int          dbt  [NSRC];
  int          mpk  [NSRC];
  int          m_last;
  logic [7:0]  m_seq;
  logic [15:0] expq [$];

  task automatic do_reset();
    @(negedge s_clk);
    s_rst = 1'b1; en = 1'b0; src_valid = '0; src_last = '0; src_data = '0; sys_tx_ready = 1'b0;
    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    s_rst = 1'b0;
  endtask

  initial begin
    int hdrs;
    bit done;
    bit found;
    int sel;
    logic [15:0] exp_w;

    // rst en  valid  last   rdy  data       txv  tx        srdy   bsy  gid
    tbl[0]  = mk(1'b1,1'b0,4'h0,4'h0,1'b1,16'h0000, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[1]  = mk(1'b0,1'b1,4'h0,4'h0,1'b1,16'h0000, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[2]  = mk(1'b0,1'b1,4'h0,4'h0,1'b1,16'h0000, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[3]  = mk(1'b0,1'b1,4'h4,4'h0,1'b1,16'h1111, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[4]  = mk(1'b0,1'b1,4'h4,4'h0,1'b1,16'h1111, 1'b1,16'hA200,4'h0,1'b1,4'h2);
    tbl[5]  = mk(1'b0,1'b1,4'h4,4'h0,1'b1,16'h1111, 1'b1,16'h1111,4'h4,1'b1,4'h2);
    tbl[6]  = mk(1'b0,1'b1,4'h4,4'h0,1'b1,16'h2222, 1'b1,16'h2222,4'h4,1'b1,4'h2);
    tbl[7]  = mk(1'b0,1'b1,4'h4,4'h4,1'b1,16'h3333, 1'b1,16'h3333,4'h4,1'b1,4'h2);
    tbl[8]  = mk(1'b0,1'b1,4'h0,4'h0,1'b1,16'h0000, 1'b0,16'h0000,4'h0,1'b0,4'h2);
    tbl[9]  = mk(1'b0,1'b1,4'h1,4'h1,1'b0,16'h5555, 1'b0,16'h0000,4'h0,1'b0,4'h2);
    tbl[10] = mk(1'b0,1'b1,4'h1,4'h1,1'b0,16'h5555, 1'b1,16'hA001,4'h0,1'b1,4'h0);
    tbl[11] = mk(1'b0,1'b1,4'h1,4'h1,1'b1,16'h5555, 1'b1,16'hA001,4'h0,1'b1,4'h0);
    tbl[12] = mk(1'b0,1'b1,4'h1,4'h1,1'b0,16'h5555, 1'b1,16'h5555,4'h0,1'b1,4'h0);
    tbl[13] = mk(1'b0,1'b1,4'h1,4'h1,1'b1,16'h5555, 1'b1,16'h5555,4'h1,1'b1,4'h0);
    tbl[14] = mk(1'b0,1'b0,4'hF,4'hF,1'b1,16'h7777, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[15] = mk(1'b0,1'b0,4'hF,4'hF,1'b1,16'h7777, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[16] = mk(1'b0,1'b1,4'hF,4'hF,1'b1,16'h7777, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[17] = mk(1'b0,1'b1,4'hF,4'hF,1'b1,16'h7777, 1'b1,16'hA102,4'h0,1'b1,4'h1);
    tbl[18] = mk(1'b0,1'b0,4'hF,4'hF,1'b1,16'h7777, 1'b1,16'h7777,4'h2,1'b1,4'h1);
    tbl[19] = mk(1'b0,1'b0,4'hF,4'hF,1'b1,16'h7777, 1'b0,16'h0000,4'h0,1'b0,4'h1);
    tbl[20] = mk(1'b0,1'b1,4'hF,4'h0,1'b1,16'h8888, 1'b0,16'h0000,4'h0,1'b0,4'h1);
    tbl[21] = mk(1'b0,1'b1,4'hF,4'h0,1'b1,16'h8888, 1'b1,16'hA203,4'h0,1'b1,4'h2);
    tbl[22] = mk(1'b0,1'b1,4'hF,4'h0,1'b1,16'h8888, 1'b1,16'h8888,4'h4,1'b1,4'h2);
    tbl[23] = mk(1'b0,1'b1,4'hB,4'h0,1'b1,16'h8888, 1'b0,16'h0000,4'h4,1'b1,4'h2);
    tbl[24] = mk(1'b0,1'b1,4'hF,4'h4,1'b1,16'h9999, 1'b1,16'h9999,4'h4,1'b1,4'h2);
    tbl[25] = mk(1'b0,1'b1,4'hF,4'hF,1'b1,16'h9999, 1'b0,16'h0000,4'h0,1'b0,4'h2);
    tbl[26] = mk(1'b0,1'b1,4'hF,4'h0,1'b1,16'hAAAA, 1'b1,16'hA304,4'h0,1'b1,4'h3);
    tbl[27] = mk(1'b0,1'b1,4'hF,4'h0,1'b1,16'hAAAA, 1'b1,16'hAAAA,4'h8,1'b1,4'h3);
    tbl[28] = mk(1'b1,1'b1,4'hF,4'h0,1'b1,16'hAAAA, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[29] = mk(1'b0,1'b1,4'hF,4'hF,1'b1,16'hBBBB, 1'b0,16'h0000,4'h0,1'b0,4'h0);
    tbl[30] = mk(1'b0,1'b1,4'hF,4'hF,1'b1,16'hBBBB, 1'b1,16'hA000,4'h0,1'b1,4'h0);
    tbl[31] = mk(1'b0,1'b1,4'hF,4'hF,1'b1,16'hBBBB, 1'b1,16'hBBBB,4'h1,1'b1,4'h0);
    tbl[32] = mk(1'b0,1'b1,4'h0,4'h0,1'b1,16'h0000, 1'b0,16'h0000,4'h0,1'b0,4'h0);

    s_rst = 1'b1; en = 1'b0; src_valid = '0; src_last = '0; src_data = '0; sys_tx_ready = 1'b0;
    repeat (3) @(posedge s_clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge s_clk);
      s_rst = tbl[i].rst; en = tbl[i].en; src_valid = tbl[i].v; src_last = tbl[i].l;
      sys_tx_ready = tbl[i].rdy; src_data = {NSRC{tbl[i].d}};
      #1;
      total++;
      if ({sys_tx_valid, sys_tx, src_ready, busy, grant_id} !==
          {tbl[i].txv, tbl[i].tx, tbl[i].srdy, tbl[i].bsy, tbl[i].gid}) begin
        bad++;
        $display("FAIL vec%0d: got txv=%b tx=%h srdy=%b busy=%b gid=%0d, want txv=%b tx=%h srdy=%b busy=%b gid=%0d",
                 i, sys_tx_valid, sys_tx, src_ready, busy, grant_id,
                 tbl[i].txv, tbl[i].tx, tbl[i].srdy, tbl[i].bsy, tbl[i].gid);
      end
    end

    // Sequence-number wrap: source 0 sends 257 single-beat packets.
    do_reset();
    en = 1'b1; src_valid = 4'h1; src_last = 4'h1; src_data = {NSRC{16'h5A5A}}; sys_tx_ready = 1'b1;
    hdrs = 0;
    for (int c = 0; c < 1200 && hdrs < 257; c++) begin
      @(negedge s_clk);
      #1;
      if (sys_tx_valid && sys_tx_ready && src_ready == 4'h0) begin
        hdrs++;
        if (hdrs == 1 || hdrs == 256 || hdrs == 257) begin
          exp_w = (hdrs == 256) ? 16'hA0FF : 16'hA000;
          total++;
          if (sys_tx !== exp_w) begin
            bad++;
            $display("FAIL seq_hdr%0d: got %h want %h", hdrs, sys_tx, exp_w);
          end
        end
      end
    end
    total++;
    if (hdrs < 257) begin
      bad++;
      $display("FAIL seq_wrap_timeout: got %0d headers want 257", hdrs);
    end

    // Randomized traffic against a packet-order model.
    for (int s = 0; s < NSRC; s++) begin
      npk[s] = int'($urandom_range(3, 7));
      for (int p = 0; p < 8; p++) plen[s][p] = int'($urandom_range(1, 4));
      dpk[s] = 0; dbt[s] = 0; mpk[s] = 0;
    end
    m_last = NSRC - 1;
    m_seq  = 8'd0;
    expq.delete();
    do_reset();
    en = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge s_clk);
      for (int s = 0; s < NSRC; s++) begin
        if (dpk[s] < npk[s]) begin
          src_valid[s] = (dbt[s] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          src_last[s]  = (dbt[s] == plen[s][dpk[s]] - 1);
          src_data[16*s +: 16] = word(s, dpk[s], dbt[s]);
        end else begin
          src_valid[s] = 1'b0;
          src_last[s]  = 1'b0;
          src_data[16*s +: 16] = 16'h0000;
        end
      end
      sys_tx_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (sys_tx_valid && sys_tx_ready) begin
        if (expq.size() == 0) begin
          found = 1'b0;
          sel = 0;
          for (int k = 1; k <= NSRC; k++) begin
            if (!found && mpk[(m_last + k) % NSRC] < npk[(m_last + k) % NSRC]) begin
              found = 1'b1;
              sel = (m_last + k) % NSRC;
            end
          end
          if (found) begin
            expq.push_back({4'hA, 4'(sel), m_seq});
            m_seq = m_seq + 8'd1;
            for (int b = 0; b < plen[sel][mpk[sel]]; b++) expq.push_back(word(sel, mpk[sel], b));
            mpk[sel]++;
            m_last = sel;
          end
        end
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: got %h want no transfer", sys_tx);
        end else begin
          exp_w = expq.pop_front();
          if (sys_tx !== exp_w) begin
            bad++;
            $display("FAIL rand_word: got %h want %h", sys_tx, exp_w);
          end
        end
      end
      for (int s = 0; s < NSRC; s++) begin
        if (src_valid[s] && src_ready[s]) begin
          if (src_last[s]) begin
            dpk[s]++;
            dbt[s] = 0;
          end else begin
            dbt[s]++;
          end
        end
      end
      done = (expq.size() == 0);
      for (int s = 0; s < NSRC; s++) begin
        if (dpk[s] != npk[s] || mpk[s] != npk[s]) done = 1'b0;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL rand_timeout: got %0d words pending want 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
